// File: rtl/ex_pkg.sv
// ex_pkg: shared widths, op codes and result record for the execute stage
package ex_pkg;
  localparam int DW = 16;
  localparam int RAW = 3;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SHI = 4'd8;
  localparam logic [3:0] OP_SHV = 4'd9;
  localparam logic [3:0] OP_LUI = 4'd10;
  localparam logic [3:0] OP_RSV_LO = 4'd11;
  typedef struct packed {
    logic [DW-1:0] result;
    logic [RAW-1:0] rd;
    logic wr;
    logic zero;
    logic ovf;
  } ex_res_t;
  function automatic logic is_rsv(input logic [3:0] op);
    return op >= OP_RSV_LO;
  endfunction
endpackage

// File: rtl/ex_if.sv
// ex_if: decode-side request, forwarding sources and memory-side result of the execute stage
interface ex_if;
  import ex_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [3:0] in_op;
  logic [RAW-1:0] in_rs;
  logic [RAW-1:0] in_rt;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] in_imm;
  logic in_use_imm;
  logic [4:0] in_shamt;
  logic [RAW-1:0] in_rd;
  logic in_wr;
  logic fm_wr;
  logic [RAW-1:0] fm_rd;
  logic [DW-1:0] fm_data;
  logic fw_wr;
  logic [RAW-1:0] fw_rd;
  logic [DW-1:0] fw_data;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_result;
  logic [RAW-1:0] out_rd;
  logic out_wr;
  logic out_zero;
  logic out_ovf;
  modport master (
    output flush, in_valid, in_op, in_rs, in_rt, in_a, in_b, in_imm, in_use_imm, in_shamt,
    output in_rd, in_wr, fm_wr, fm_rd, fm_data, fw_wr, fw_rd, fw_data, out_ready,
    input in_ready, out_valid, out_result, out_rd, out_wr, out_zero, out_ovf
  );
  modport slave (
    input flush, in_valid, in_op, in_rs, in_rt, in_a, in_b, in_imm, in_use_imm, in_shamt,
    input in_rd, in_wr, fm_wr, fm_rd, fm_data, fw_wr, fw_rd, fw_data, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr, out_zero, out_ovf
  );
endinterface

// File: rtl/ex_fwd_mux.sv
// ex_fwd_mux: operand bypass, r0 first, then EX/MEM, then MEM/WB, then register file
module ex_fwd_mux #(
  parameter int DW = 16,
  parameter int RAW = 3
) (
  input logic [RAW-1:0] addr,
  input logic [DW-1:0] rf,
  input logic fm_wr,
  input logic [RAW-1:0] fm_rd,
  input logic [DW-1:0] fm_data,
  input logic fw_wr,
  input logic [RAW-1:0] fw_rd,
  input logic [DW-1:0] fw_data,
  output logic [DW-1:0] y
);
  // priority select, youngest producer wins
  always_comb begin
    y = addr == '0 ? '0 :
        fm_wr && fm_rd == addr ? fm_data :
        fw_wr && fw_rd == addr ? fw_data : rf;
  end
endmodule

// File: rtl/shifter.sv
// shifter: 16-bit logical shift, signed 5-bit amount, positive left, negative right
module shifter (
  input logic [15:0] a,
  input logic [4:0] amt,
  output logic [15:0] y
);
  logic [4:0] mag;
  // a magnitude of 16 only arises from -16 and clears the word
  always_comb begin
    mag = -amt;
    y = amt[4] ? (mag[4] ? 16'h0000 : a >> mag[3:0]) : a << amt[3:0];
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarded ALU/shift execute stage with a valid/ready EX/MEM register
module ex_stage
  import ex_pkg::*;
(
  input logic clk,
  input logic rst_n,
  ex_if.slave bus
);
  logic [DW-1:0] a, b_fwd, b, sh_y, r;
  logic [4:0] sh_amt;
  logic ovf, valid, accept;
  ex_res_t d, q;
  ex_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_a (
    .addr(bus.in_rs), .rf(bus.in_a),
    .fm_wr(bus.fm_wr), .fm_rd(bus.fm_rd), .fm_data(bus.fm_data),
    .fw_wr(bus.fw_wr), .fw_rd(bus.fw_rd), .fw_data(bus.fw_data),
    .y(a)
  );
  ex_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_b (
    .addr(bus.in_rt), .rf(bus.in_b),
    .fm_wr(bus.fm_wr), .fm_rd(bus.fm_rd), .fm_data(bus.fm_data),
    .fw_wr(bus.fw_wr), .fw_rd(bus.fw_rd), .fw_data(bus.fw_data),
    .y(b_fwd)
  );
  shifter u_sh (.a(a), .amt(sh_amt), .y(sh_y));
  assign bus.in_ready = !valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  // operand select, op decode, flags and next register contents
  always_comb begin
    b = bus.in_use_imm ? bus.in_imm : b_fwd;
    sh_amt = bus.in_op == OP_SHI ? bus.in_shamt : b[4:0];
    r = bus.in_op == OP_ADD ? a + b :
        bus.in_op == OP_SUB ? a - b :
        bus.in_op == OP_AND ? a & b :
        bus.in_op == OP_OR ? a | b :
        bus.in_op == OP_XOR ? a ^ b :
        bus.in_op == OP_NOR ? ~(a | b) :
        bus.in_op == OP_SLT ? {{(DW-1){1'b0}}, $signed(a) < $signed(b)} :
        bus.in_op == OP_SLTU ? {{(DW-1){1'b0}}, a < b} :
        bus.in_op == OP_SHI || bus.in_op == OP_SHV ? sh_y :
        bus.in_op == OP_LUI ? {b[7:0], 8'h00} : '0;
    ovf = (bus.in_op == OP_ADD && a[DW-1] == b[DW-1] && r[DW-1] != a[DW-1]) ||
          (bus.in_op == OP_SUB && a[DW-1] != b[DW-1] && r[DW-1] != a[DW-1]);
    d.result = r;
    d.rd = bus.in_rd;
    d.wr = bus.in_wr && bus.in_rd != '0 && !is_rsv(bus.in_op);
    d.zero = r == '0;
    d.ovf = ovf;
  end
  // EX/MEM register: reset, then flush, then load, then drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else if (bus.flush) begin
      valid <= 1'b0;
      q.wr <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      q <= d;
    end else if (bus.out_ready) begin
      valid <= 1'b0;
    end
  end
  assign bus.out_valid = valid;
  assign bus.out_result = q.result;
  assign bus.out_rd = q.rd;
  assign bus.out_wr = q.wr;
  assign bus.out_zero = q.zero;
  assign bus.out_ovf = q.ovf;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for the execute stage
module tb_ex_stage;
  typedef struct packed {
    logic [15:0] r;
    logic [2:0] rd;
    logic wr;
    logic z;
    logic v;
  } exp_t;
  typedef struct {
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic imm;
    logic [4:0] sh;
    logic [15:0] r;
    logic v;
  } vec_t;
  typedef struct {
    logic [2:0] rs, rt;
    logic [15:0] a, b;
    logic fmw;
    logic [2:0] fmrd;
    logic [15:0] fmd;
    logic fww;
    logic [2:0] fwrd;
    logic [15:0] fwd;
    logic [15:0] r;
  } fvec_t;
  logic clk = 0;
  logic rst_n = 0;
  int pass_cnt = 0;
  int total = 0;
  exp_t sb[$];
  exp_t e;
  ex_if bus ();
  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  vec_t alu[16] = '{
    '{4'd0, 16'h7FFF, 16'h0001, 1'b0, 5'd0, 16'h8000, 1'b1},
    '{4'd0, 16'h1234, 16'h0001, 1'b1, 5'd0, 16'h1235, 1'b0},
    '{4'd1, 16'h0005, 16'h0007, 1'b0, 5'd0, 16'hFFFE, 1'b0},
    '{4'd1, 16'h8000, 16'h0001, 1'b0, 5'd0, 16'h7FFF, 1'b1},
    '{4'd2, 16'hF0F0, 16'hFF00, 1'b0, 5'd0, 16'hF000, 1'b0},
    '{4'd3, 16'hF0F0, 16'h0F00, 1'b0, 5'd0, 16'hFFF0, 1'b0},
    '{4'd4, 16'hFFFF, 16'hFFFF, 1'b0, 5'd0, 16'h0000, 1'b0},
    '{4'd5, 16'h0F0F, 16'h00F0, 1'b0, 5'd0, 16'hF000, 1'b0},
    '{4'd6, 16'hFFFF, 16'h0001, 1'b0, 5'd0, 16'h0001, 1'b0},
    '{4'd7, 16'hFFFF, 16'h0001, 1'b0, 5'd0, 16'h0000, 1'b0},
    '{4'd8, 16'h0001, 16'h0000, 1'b0, 5'b00100, 16'h0010, 1'b0},
    '{4'd8, 16'h8000, 16'h0000, 1'b0, 5'b11100, 16'h0800, 1'b0},
    '{4'd9, 16'h1234, 16'h0010, 1'b0, 5'd0, 16'h0000, 1'b0},
    '{4'd9, 16'h0001, 16'h000F, 1'b0, 5'd0, 16'h8000, 1'b0},
    '{4'd10, 16'h5555, 16'h00AB, 1'b1, 5'd0, 16'hAB00, 1'b0},
    '{4'd12, 16'hFFFF, 16'h0001, 1'b0, 5'd0, 16'h0000, 1'b0}
  };
  fvec_t fwv[5] = '{
    '{3'd3, 3'd0, 16'h1111, 16'hAAAA, 1'b1, 3'd3, 16'h2222, 1'b1, 3'd3, 16'h3333, 16'h2222},
    '{3'd3, 3'd0, 16'h1111, 16'hAAAA, 1'b0, 3'd3, 16'h2222, 1'b1, 3'd3, 16'h3333, 16'h3333},
    '{3'd0, 3'd0, 16'h1111, 16'hAAAA, 1'b1, 3'd0, 16'h2222, 1'b1, 3'd0, 16'h3333, 16'h0000},
    '{3'd1, 3'd5, 16'h0001, 16'h0100, 1'b1, 3'd5, 16'h0200, 1'b1, 3'd5, 16'h0300, 16'h0201},
    '{3'd6, 3'd5, 16'h0001, 16'h0100, 1'b0, 3'd5, 16'h0200, 1'b0, 3'd5, 16'h0300, 16'h0101}
  };
  task automatic send(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] imm, input logic use_imm, input logic [4:0] sh,
                      input logic wr, input logic [15:0] er, input logic ev);
    exp_t x;
    bus.in_valid = 1;
    bus.in_op = op;
    bus.in_rs = rs;
    bus.in_rt = rt;
    bus.in_rd = rd;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_imm = imm;
    bus.in_use_imm = use_imm;
    bus.in_shamt = sh;
    bus.in_wr = wr;
    x.r = er;
    x.rd = rd;
    x.wr = wr && rd != 3'd0 && op < 4'd11;
    x.z = er == 16'h0000;
    x.v = ev;
    sb.push_back(x);
  endtask
  task automatic test_reset;
    send(4'd0, 3'd1, 3'd2, 3'd4, 16'h1234, 16'h4321, 16'h0, 1'b0, 5'd0, 1'b1, 16'h5555, 1'b0);
    sb.pop_back();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== 23'h0) begin
      $display("FAIL reset_outputs got v=%b r=%h rd=%0d wr=%b z=%b o=%b want all 0",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf);
    end else pass_cnt++;
    bus.in_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL reset_idle got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end else pass_cnt++;
  endtask
  task automatic test_alu;
    foreach (alu[i]) begin
      send(alu[i].op, 3'd1, 3'd2, 3'd4, alu[i].a, alu[i].imm ? ~alu[i].b : alu[i].b,
           alu[i].imm ? alu[i].b : ~alu[i].b, alu[i].imm, alu[i].sh, 1'b1, alu[i].r, alu[i].v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== e) begin
        $display("FAIL alu[%0d] got v=%b r=%h rd=%0d wr=%b z=%b o=%b want v=1 r=%h rd=%0d wr=%b z=%b o=%b",
                 i, bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf,
                 e.r, e.rd, e.wr, e.z, e.v);
      end else pass_cnt++;
    end
    bus.in_valid = 0;
  endtask
  task automatic test_forward;
    foreach (fwv[i]) begin
      bus.fm_wr = fwv[i].fmw;
      bus.fm_rd = fwv[i].fmrd;
      bus.fm_data = fwv[i].fmd;
      bus.fw_wr = fwv[i].fww;
      bus.fw_rd = fwv[i].fwrd;
      bus.fw_data = fwv[i].fwd;
      send(4'd0, fwv[i].rs, fwv[i].rt, 3'd7, fwv[i].a, fwv[i].b, 16'hFFFF, 1'b0, 5'd0, 1'b1,
           fwv[i].r, 1'b0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.out_valid !== 1'b1 ||
          {bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== e) begin
        $display("FAIL fwd[%0d] got v=%b r=%h rd=%0d wr=%b z=%b o=%b want v=1 r=%h rd=%0d wr=%b z=%b o=%b",
                 i, bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf,
                 e.r, e.rd, e.wr, e.z, e.v);
      end else pass_cnt++;
    end
    bus.in_valid = 0;
    bus.fm_wr = 0;
    bus.fw_wr = 0;
  endtask
  task automatic test_back_to_back;
    send(4'd1, 3'd1, 3'd2, 3'd4, 16'h0005, 16'h0007, 16'h0, 1'b0, 5'd0, 1'b1, 16'hFFFE, 1'b0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== e) begin
      $display("FAIL bp_first got v=%b r=%h want v=1 r=%h", bus.out_valid, bus.out_result, e.r);
    end else pass_cnt++;
    bus.out_ready = 0;
    send(4'd0, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0001, 16'h0, 1'b0, 5'd0, 1'b1, 16'h0002, 1'b0);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL bp_ready_low got in_ready=%b want 0", bus.in_ready);
    end else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hFFFE || bus.out_rd !== 3'd4 ||
          bus.in_ready !== 1'b0) begin
        $display("FAIL bp_hold[%0d] got v=%b r=%h rd=%0d in_ready=%b want v=1 r=fffe rd=4 in_ready=0",
                 k, bus.out_valid, bus.out_result, bus.out_rd, bus.in_ready);
      end else pass_cnt++;
    end
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    e = sb.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== e) begin
      $display("FAIL bp_second got v=%b r=%h rd=%0d want v=1 r=%h rd=%0d",
               bus.out_valid, bus.out_result, bus.out_rd, e.r, e.rd);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0002) begin
      $display("FAIL drain got v=%b r=%h want v=0 r=0002", bus.out_valid, bus.out_result);
    end else pass_cnt++;
  endtask
  task automatic test_flush;
    send(4'd0, 3'd1, 3'd2, 3'd2, 16'h0001, 16'h0001, 16'h0, 1'b0, 5'd0, 1'b1, 16'h0002, 1'b0);
    sb.pop_back();
    bus.flush = 1;
    @(posedge clk);
    #1;
    bus.flush = 0;
    bus.in_valid = 0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_wr !== 1'b0) begin
      $display("FAIL flush got v=%b wr=%b want 0 0", bus.out_valid, bus.out_wr);
    end else pass_cnt++;
  endtask
  task automatic test_reset_hold;
    send(4'd4, 3'd1, 3'd2, 3'd5, 16'hFFFF, 16'h0000, 16'h0, 1'b0, 5'd0, 1'b1, 16'hFFFF, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.out_ready = 0;
    e = sb.pop_front();
    total++;
    if (bus.out_valid !== 1'b1 ||
        {bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== e) begin
      $display("FAIL rh_load got v=%b r=%h want v=1 r=%h", bus.out_valid, bus.out_result, e.r);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf} !== 23'h0) begin
      $display("FAIL reset_hold got v=%b r=%h rd=%0d wr=%b z=%b o=%b want all 0",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_wr, bus.out_zero, bus.out_ovf);
    end else pass_cnt++;
    rst_n = 1;
    bus.out_ready = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_op = 0;
    bus.in_rs = 0;
    bus.in_rt = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.in_imm = 0;
    bus.in_use_imm = 0;
    bus.in_shamt = 0;
    bus.in_rd = 0;
    bus.in_wr = 0;
    bus.fm_wr = 0;
    bus.fm_rd = 0;
    bus.fm_data = 0;
    bus.fw_wr = 0;
    bus.fw_rd = 0;
    bus.fw_data = 0;
    bus.out_ready = 1;
    test_reset;
    test_alu;
    test_forward;
    test_back_to_back;
    test_flush;
    test_reset_hold;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
